// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types and constants for the byte-serial shared adder
package adder_share_pkg;

    localparam int NBYTES_DEFAULT = 4;
    localparam int ID_W           = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_8bit.sv
// rtl/adder_8bit.sv - gate-level 8-bit ripple-carry adder
module adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic [8:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[8];

endmodule

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - two-requester round-robin front end for a byte-serial shared adder
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT,
    parameter int W      = 8 * NBYTES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [W-1:0]    req_a0,
    input  logic [W-1:0]    req_b0,
    input  logic [W-1:0]    req_a1,
    input  logic [W-1:0]    req_b1,
    input  logic [1:0]      req_cin,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [W-1:0]    res_sum,
    output logic            res_cout,
    output logic [ID_W-1:0] res_id
);

    localparam int               IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    state_e          state_q;
    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] id_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            cout_q;
    logic            accept;
    logic [7:0]      add_sum;
    logic            add_cout;

    // Contested cycles go to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant = '0;
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end else if (req_valid[1] && !req_valid[0]) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state_q == IDLE) && req_valid[grant]) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    adder_8bit u_adder (
        .a_i    (a_q[{idx_q, 3'b000} +: 8]),
        .b_i    (b_q[{idx_q, 3'b000} +: 8]),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= '1;
            id_q         <= '0;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= grant ? req_a1 : req_a0;
                        b_q          <= grant ? req_b1 : req_b0;
                        carry_q      <= req_cin[grant];
                        id_q         <= grant;
                        last_grant_q <= grant;
                        idx_q        <= '0;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    sum_q[{idx_q, 3'b000} +: 8] <= add_sum;
                    carry_q                     <= add_cout;
                    idx_q                       <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        cout_q  <= add_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - self-checking bench for adder_share_ctrl
module tb_adder_share_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   req_cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;

    int n_checks = 0;
    int n_errors = 0;
    int last_g   = 1;
    int order_q[$];

    always #5 clk = ~clk;

    adder_share_ctrl #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (id == 0) begin
            req_a0 = a;
            req_b0 = b;
        end else begin
            req_a1 = a;
            req_b1 = b;
        end
        req_cin[id]   = cin;
        req_valid[id] = 1'b1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // One request from a single requester; optional DONE stall and post-accept operand scrambling.
    task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int stall, input bit corrupt);
        logic [W:0] exp;
        logic [1:0] onehot;
        logic [1:0] other_hot;
        int cnt;
        onehot    = (id == 0) ? 2'b01 : 2'b10;
        other_hot = ~onehot;
        exp       = ref_add(a, b, cin);
        res_ready = 1'b0;
        set_req(id, a, b, cin);
        #1;
        cnt = 0;
        while (req_ready !== onehot && cnt < 10) begin
            tick();
            #1;
            cnt++;
        end
        check("accept_ready", req_ready, onehot);
        tick();
        last_g        = id;
        req_valid[id] = 1'b0;
        if (corrupt) begin
            if (id == 0) begin
                req_a0 = ~a;
                req_b0 = ~b;
            end else begin
                req_a1 = ~a;
                req_b1 = ~b;
            end
            req_cin[id] = ~cin;
        end
        #1;
        check("calc_ready", req_ready, 2'b00);
        cnt = 0;
        while (!res_valid && cnt < 20) begin
            tick();
            #1;
            cnt++;
        end
        check("latency", cnt, NB);
        check("sum", res_sum, exp[W-1:0]);
        check("cout", res_cout, exp[W]);
        check("id", res_id, id);
        if (stall > 0) begin
            set_req(1 - id, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            #1;
            check("hold_valid", res_valid, 1'b1);
            check("hold_sum", res_sum, exp[W-1:0]);
            check("hold_cout", res_cout, exp[W]);
            check("hold_ready", req_ready, 2'b00);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        #1;
        check("idle_valid", res_valid, 1'b0);
        if (stall > 0) begin
            check("idle_ready", req_ready, other_hot);
            req_valid = 2'b00;
        end
    endtask

    // Cycle-level scoreboard: round-robin grant rule, NB-cycle latency, sum, stall hold.
    task automatic run_rr(input int want, input int max_cycles, input bit rnd);
        int done_n;
        int cyc;
        int cnt;
        int g;
        bit busy;
        bit acc;
        bit hs;
        logic [1:0] exp_rdy;
        logic [W:0] exp_v;
        logic exp_id;
        done_n = 0;
        cyc    = 0;
        cnt    = 0;
        busy   = 1'b0;
        exp_v  = '0;
        exp_id = 1'b0;
        while (done_n < want && cyc < max_cycles) begin
            if (rnd) begin
                for (int r = 0; r < 2; r++) begin
                    if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
                        set_req(r, $urandom, $urandom, 1'($urandom_range(0, 1)));
                    end
                end
                res_ready = 1'($urandom_range(0, 1));
            end
            #1;
            exp_rdy = 2'b00;
            if (!busy) begin
                if (req_valid == 2'b11) exp_rdy = (last_g == 1) ? 2'b01 : 2'b10;
                else                    exp_rdy = req_valid;
            end
            check("rr_ready", req_ready, exp_rdy);
            check("rr_valid", res_valid, busy && cnt >= NB);
            hs = 1'b0;
            if (busy && cnt >= NB) begin
                check("rr_sum", res_sum, exp_v[W-1:0]);
                check("rr_cout", res_cout, exp_v[W]);
                check("rr_id", res_id, exp_id);
                hs = res_ready;
                if (hs) order_q.push_back(int'(res_id));
            end
            acc = |(req_ready & req_valid);
            g   = req_ready[1] ? 1 : 0;
            if (acc) begin
                exp_v  = (g == 1) ? ref_add(req_a1, req_b1, req_cin[1]) : ref_add(req_a0, req_b0, req_cin[0]);
                exp_id = 1'(g);
                last_g = g;
            end
            tick();
            cyc++;
            if (busy) cnt++;
            if (hs) begin
                busy = 1'b0;
                done_n++;
            end
            if (acc) begin
                busy         = 1'b1;
                cnt          = 0;
                req_valid[g] = 1'b0;
            end
        end
        check("rr_done", done_n, want);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        res_ready = 1'b0;
        req_cin   = 2'b10;
        req_a0    = 32'h0000_1111;
        req_b0    = 32'h0000_2222;
        req_a1    = 32'hFFFF_0000;
        req_b1    = 32'h0001_0000;
        req_valid = 2'b11;
        repeat (3) tick();
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_valid", res_valid, 1'b0);
        check("rst_sum", res_sum, '0);
        check("rst_cout", res_cout, 1'b0);
        check("rst_id", res_id, 1'b0);

        // Both requesters pending out of reset: requester 0 first, then 1.
        rst_n     = 1'b1;
        res_ready = 1'b1;
        last_g    = 1;
        order_q.delete();
        run_rr(2, 40, 1'b0);
        check("order_len", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check("order_first", order_q[0], 0);
            check("order_second", order_q[1], 1);
        end
        res_ready = 1'b0;
        req_valid = 2'b00;

        single(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        single(1, 32'h1234_5678, 32'h1111_1111, 1'b1, 0, 1'b0);
        single(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 3, 1'b0);
        single(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b1);

        // Abort an operation two bytes into CALC.
        set_req(1, 32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b1);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", res_valid, 1'b0);
        check("abort_sum", res_sum, '0);
        check("abort_cout", res_cout, 1'b0);
        check("abort_id", res_id, 1'b0);
        check("abort_ready", req_ready, 2'b00);
        tick();
        rst_n  = 1'b1;
        last_g = 1;
        for (int i = 0; i < NB + 2; i++) begin
            tick();
            check("abort_no_result", res_valid, 1'b0);
        end
        single(0, 32'h0000_0001, 32'h0000_0001, 1'b0, 0, 1'b0);

        req_valid = 2'b00;
        run_rr(30, 2000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4: operand width in bytes, legal range 2..8.
REQ-002 The block SHALL have parameter W, default 8*NBYTES: operand and sum width in bits, derived, not overridden.
REQ-003 One clock and one reset SHALL exist; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 2 bits: per-requester add request.
REQ-007 The block SHALL have port req_ready, output, 2 bits: per-requester accept, at most one bit high.
REQ-008 The block SHALL have ports req_a0 and req_b0, input, W bits each: requester 0 operands.
REQ-009 The block SHALL have ports req_a1 and req_b1, input, W bits each: requester 1 operands.
REQ-010 The block SHALL have port req_cin, input, 2 bits: per-requester carry-in.
REQ-011 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port res_ready, input, 1 bit: result consumer accept.
REQ-013 The block SHALL have port res_sum, output, W bits: the W-bit sum.
REQ-014 The block SHALL have port res_cout, output, 1 bit: carry out of bit W-1.
REQ-015 The block SHALL have port res_id, output, 1 bit: index of the requester that owns the result.

Function
REQ-016 The FSM SHALL have states IDLE, CALC and DONE.
REQ-017 In IDLE, req_ready[g] SHALL be driven combinationally high only for the granted requester g whose req_valid is high.
REQ-018 In CALC and DONE, req_ready SHALL be 2'b00.
REQ-019 Arbitration SHALL be round-robin: with both requesters valid, grant goes to the one not granted last; with one valid, grant goes to it.
REQ-020 The last-grant register SHALL reset to 1, so requester 0 wins first.
REQ-021 On the accept edge (req_valid[g] and req_ready[g] both high), the block SHALL latch operands, cin and id g, set byte index 0 and enter CALC.
REQ-022 Operand changes after the accept edge SHALL be ignored.
REQ-023 Each CALC cycle SHALL pass byte[idx] of both operands and the carry register through one shared 8-bit adder.
REQ-024 Each CALC cycle SHALL write the 8-bit sum into res_sum byte idx, load the adder carry-out into the carry register and increment idx.
REQ-025 The carry register SHALL be loaded with the latched cin at the accept edge.
REQ-026 On the CALC edge with idx = NBYTES-1, the block SHALL enter DONE and load res_cout from the final adder carry-out.
REQ-027 res_valid SHALL be high exactly in DONE and rise NBYTES cycles after the accept edge.
REQ-028 In DONE, res_sum, res_cout and res_id SHALL be held stable while res_ready is low, for unbounded backpressure.
REQ-029 When res_valid and res_ready are both high, the block SHALL return to IDLE on that edge.
REQ-030 A new accept SHALL occur no earlier than the cycle after the DONE→IDLE transition; minimum throughput is one result per NBYTES+2 cycles.
REQ-031 Arithmetic SHALL be unsigned modulo 2^W with carry-out; overflow SHALL be reported only via res_cout.

Reset
REQ-032 With rst_n low, the block SHALL force state IDLE, req_ready 0, res_valid 0, res_sum 0, res_cout 0, res_id 0, idx 0, carry register 0 and last-grant 1.
REQ-033 On reset assertion mid-CALC or in DONE, the block SHALL discard the in-flight operation with no result emitted.
REQ-034 Reset release SHALL be synchronised externally; no internal synchroniser SHALL exist.

Structure
REQ-035 A shared package adder_share_pkg SHALL hold the state enum typedef, NBYTES_DEFAULT = 4 and the requester-id width.
REQ-036 The block SHALL instantiate exactly one sub-module, the team's existing gate-level ripple adder adder_8bit, as the shared datapath; there SHALL be no other adder logic.

Verification
REQ-037 The bench SHALL cover: req0 a=0xFFFFFFFF, b=0x00000001, cin=0 -> res_sum=0x00000000, res_cout=1, res_id=0, res_valid 4 cycles after accept.
REQ-038 The bench SHALL cover: req1 a=0x12345678, b=0x11111111, cin=1 -> res_sum=0x2345678A, res_cout=0, res_id=1.
REQ-039 The bench SHALL cover: both req_valid high from reset, res_ready tied 1 -> req0 served first, req1 second, both sums correct, req_ready never 2'b11.
REQ-040 The bench SHALL cover: res_ready low for 3 cycles in DONE -> res_valid and res_sum held, req_ready stays 0, IDLE follows the handshake edge.
REQ-041 The bench SHALL cover: rst_n pulsed low during CALC idx=2 -> all outputs 0 immediately, no res_valid, next request 0x00000001+0x00000001 -> 0x00000002.
REQ-042 The bench SHALL cover: operands changed the cycle after accept -> result reflects the latched values only.
